// File: rtl/line_walker.sv
// line_walker: streams the pixels of an arbitrary-octant line segment over valid/ready,
// stepping one pixel per accepted handshake with integer Bresenham error arithmetic.
module line_walker #(
    parameter int COORD_W = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    output logic                      busy,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic signed [COORD_W-1:0] pix_x,
    output logic signed [COORD_W-1:0] pix_y,
    output logic                      pix_last,
    output logic                      done
);
    localparam int W1 = COORD_W + 1;
    localparam int W2 = COORD_W + 2;
    localparam int W3 = COORD_W + 3;
    localparam logic signed [COORD_W-1:0] ONE = COORD_W'(1);

    typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_e;
    state_e state_q, state_d;

    logic signed [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic signed [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d, nx, ny;
    logic signed [W1-1:0]      dx_q, dx_d, dy_q, dy_d, ddx, ddy, adx, ady;
    logic signed [W2-1:0]      err_q, err_d, err_step;
    logic signed [W3-1:0]      e2;
    logic sx_q, sx_d, sy_q, sy_d;
    logic valid_q, valid_d, last_q, last_d, done_q, done_d;
    logic step_x, step_y, hs;

    assign ddx      = W1'(x1_q) - W1'(x0_q);
    assign ddy      = W1'(y1_q) - W1'(y0_q);
    assign adx      = ddx[W1-1] ? -ddx : ddx;
    assign ady      = ddy[W1-1] ? -ddy : ddy;
    assign hs       = valid_q & pix_ready;
    assign e2       = W3'(err_q) <<< 1;
    assign step_x   = e2 >= W3'(dy_q);
    assign step_y   = e2 <= W3'(dx_q);
    // sx/sy hold 1 for a negative step direction
    assign nx       = step_x ? (sx_q ? cx_q - ONE : cx_q + ONE) : cx_q;
    assign ny       = step_y ? (sy_q ? cy_q - ONE : cy_q + ONE) : cy_q;
    assign err_step = err_q + (step_x ? W2'(dy_q) : '0) + (step_y ? W2'(dx_q) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                end
            end
            SETUP: begin
                state_d = abort ? IDLE : EMIT;
                dx_d    = adx;
                dy_d    = -ady;
                sx_d    = !(x0_q < x1_q);
                sy_d    = !(y0_q < y1_q);
                err_d   = W2'(adx) - W2'(ady);
                cx_d    = x0_q;
                cy_d    = y0_q;
                valid_d = !abort;
                last_d  = !abort && (x0_q == x1_q) && (y0_q == y1_q);
            end
            EMIT: begin
                if (abort || (hs && last_q)) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = !abort;
                end else if (hs) begin
                    cx_d   = nx;
                    cy_d   = ny;
                    err_d  = err_step;
                    last_d = (nx == x1_q) && (ny == y1_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != IDLE;
        pix_valid = valid_q;
        pix_x     = cx_q;
        pix_y     = cy_q;
        pix_last  = last_q;
        done      = done_q;
    end
endmodule
